// File: rtl/multicycle_decoder.sv
// Multicycle control FSM for the MIPS-subset core: latches one instruction per handshake and
// walks it through DECODE/EXEC/MEM/MULT/WB, driving the datapath controls for each phase.
module multicycle_decoder #(
  parameter int MULT_CYCLES = 4,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_instr_valid,
  output logic                  o_instr_ready,
  input  logic [31:0]           i_instr,
  input  logic                  i_zero,
  input  logic                  i_mem_ready,
  output logic                  o_memtoreg,
  output logic                  o_memread,
  output logic                  o_memwrite,
  output logic                  o_dobranch,
  output logic                  o_dojump,
  output logic                  o_alusrcbimm,
  output logic [2:0]            o_alucontrol,
  output logic [REG_ADDR_W-1:0] o_destreg,
  output logic                  o_regwrite,
  output logic                  o_hilo_write,
  output logic [1:0]            o_hilo_sel,
  output logic                  o_illegal
);

  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_MULT, S_WB
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_ALU_R, K_ADDIU, K_LUI, K_ORI, K_LW, K_SW,
    K_BEQ, K_BLTZ, K_J, K_MULTU, K_MFHI, K_MFLO
  } kind_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_mult_cnt;

  kind_t            w_kind;
  logic [2:0]       w_exec_alu;
  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic             w_mult_last;
  logic             w_unused;

  assign w_op        = r_instr[31:26];
  assign w_funct     = r_instr[5:0];
  assign w_rt        = r_instr[20:16];
  assign w_rd        = r_instr[15:11];
  assign w_mult_last = (r_mult_cnt == CNT_W'(MULT_CYCLES - 1));
  assign w_unused    = ^r_instr;

  // Classification works only on the latched word, so instr may change after the handshake.
  always_comb begin
    w_kind     = K_ILL;
    w_exec_alu = 3'b000;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h21: begin w_kind = K_ALU_R; w_exec_alu = 3'b101; end
          6'h23: begin w_kind = K_ALU_R; w_exec_alu = 3'b001; end
          6'h24: begin w_kind = K_ALU_R; w_exec_alu = 3'b111; end
          6'h25: begin w_kind = K_ALU_R; w_exec_alu = 3'b110; end
          6'h2B: begin w_kind = K_ALU_R; w_exec_alu = 3'b000; end
          6'h19: begin w_kind = K_MULTU; w_exec_alu = 3'b100; end
          6'h10: w_kind = K_MFHI;
          6'h12: w_kind = K_MFLO;
          default: ;
        endcase
      end
      6'h01: if (w_rt == 5'd0) begin w_kind = K_BLTZ; w_exec_alu = 3'b010; end
      6'h02: w_kind = K_J;
      6'h04: begin w_kind = K_BEQ;   w_exec_alu = 3'b001; end
      6'h09: begin w_kind = K_ADDIU; w_exec_alu = 3'b101; end
      6'h0D: begin w_kind = K_ORI;   w_exec_alu = 3'b110; end
      6'h0F: begin w_kind = K_LUI;   w_exec_alu = 3'b011; end
      6'h23: begin w_kind = K_LW;    w_exec_alu = 3'b101; end
      6'h2B: begin w_kind = K_SW;    w_exec_alu = 3'b101; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The counter wraps to zero on the last MULT cycle so every multu starts from a clean count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_instr    <= '0;
      r_mult_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && i_instr_valid) begin
        r_instr <= i_instr;
      end
      if (r_state == S_MULT) begin
        r_mult_cnt <= w_mult_last ? '0 : r_mult_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_instr_valid) w_next = S_DECODE;
      S_DECODE: w_next = (w_kind == K_ILL) ? S_IDLE : S_EXEC;
      S_EXEC: begin
        case (w_kind)
          K_BEQ, K_BLTZ, K_J: w_next = S_IDLE;
          K_LW, K_SW:         w_next = S_MEM;
          K_MULTU:            w_next = S_MULT;
          default:            w_next = S_WB;
        endcase
      end
      S_MEM:    if (i_mem_ready) w_next = (w_kind == K_LW) ? S_WB : S_IDLE;
      S_MULT:   if (w_mult_last) w_next = S_IDLE;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_instr_ready = 1'b0;
    o_memtoreg    = 1'b0;
    o_memread     = 1'b0;
    o_memwrite    = 1'b0;
    o_dobranch    = 1'b0;
    o_dojump      = 1'b0;
    o_alusrcbimm  = 1'b0;
    o_alucontrol  = 3'b000;
    o_destreg     = '0;
    o_regwrite    = 1'b0;
    o_hilo_write  = 1'b0;
    o_hilo_sel    = 2'b00;
    o_illegal     = 1'b0;
    case (r_state)
      S_IDLE:   o_instr_ready = 1'b1;
      S_DECODE: o_illegal = (w_kind == K_ILL);
      S_EXEC: begin
        o_alucontrol = w_exec_alu;
        o_alusrcbimm = (w_kind == K_LW) || (w_kind == K_SW) || (w_kind == K_ADDIU) ||
                       (w_kind == K_LUI) || (w_kind == K_ORI);
        o_dobranch   = ((w_kind == K_BEQ) || (w_kind == K_BLTZ)) && i_zero;
        o_dojump     = (w_kind == K_J);
      end
      S_MEM: begin
        o_memread  = (w_kind == K_LW);
        o_memwrite = (w_kind == K_SW);
      end
      S_MULT: begin
        o_alucontrol = 3'b100;
        o_hilo_write = w_mult_last;
      end
      S_WB: begin
        o_regwrite = 1'b1;
        o_memtoreg = (w_kind == K_LW);
        o_destreg  = ((w_kind == K_ALU_R) || (w_kind == K_MFHI) || (w_kind == K_MFLO)) ?
                     w_rd[REG_ADDR_W-1:0] : w_rt[REG_ADDR_W-1:0];
        o_hilo_sel = (w_kind == K_MFHI) ? 2'b01 : (w_kind == K_MFLO) ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

endmodule
